// File: rtl/alu_control_mc_pkg.sv
// Shared ALU control constants: operation selects, ALU_Op classes, funct7 patterns and FSM states.
// The ALU_CONTROL_M_EXT_EN macro (used by the decoder and top) enables multi-cycle multiply/divide.
package alu_control_mc_pkg;

  typedef logic [3:0] alu_sel_t;

  localparam alu_sel_t OP_ADD  = 4'b0000;
  localparam alu_sel_t OP_SUB  = 4'b0001;
  localparam alu_sel_t OP_AND  = 4'b0010;
  localparam alu_sel_t OP_OR   = 4'b0011;
  localparam alu_sel_t OP_XOR  = 4'b0100;
  localparam alu_sel_t OP_LUI  = 4'b0101;
  localparam alu_sel_t OP_SRL  = 4'b0110;
  localparam alu_sel_t OP_SLL  = 4'b0111;
  localparam alu_sel_t OP_SRA  = 4'b1000;
  localparam alu_sel_t OP_SLT  = 4'b1001;
  localparam alu_sel_t OP_SLTU = 4'b1010;
  localparam alu_sel_t OP_MUL  = 4'b1011;
  localparam alu_sel_t OP_MULH = 4'b1100;
  localparam alu_sel_t OP_DIV  = 4'b1101;
  localparam alu_sel_t OP_REM  = 4'b1110;

  localparam logic [2:0] CLS_R   = 3'b000;
  localparam logic [2:0] CLS_I   = 3'b001;
  localparam logic [2:0] CLS_MEM = 3'b010;
  localparam logic [2:0] CLS_BR  = 3'b011;
  localparam logic [2:0] CLS_LUI = 3'b100;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  // funct3 -> operation for the base (non-alternate) encodings shared by R and I types
  function automatic alu_sel_t f3_to_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode_table.sv
// Combinational ALU_Op/funct3/funct7 -> operation select decode; flags illegal and multi-cycle ops.
// M-extension entries exist only when ALU_CONTROL_M_EXT_EN is defined, otherwise they decode illegal.
module alu_decode_table
  import alu_control_mc_pkg::*;
#(
  parameter int ALU_OP_W = 3
) (
  input  logic [ALU_OP_W-1:0] alu_op_i,
  input  logic [2:0]          funct3_i,
  input  logic [6:0]          funct7_i,
  output alu_sel_t            op_o,
  output logic                illegal_o,
  output logic                md_o
);

  alu_sel_t op_raw;
  logic     bad;

  always_comb begin
    op_raw = OP_ADD;
    bad    = 1'b0;
    md_o   = 1'b0;
    if (alu_op_i == ALU_OP_W'(CLS_R)) begin
      if (funct7_i == F7_BASE) begin
        op_raw = f3_to_op(funct3_i);
      end else if (funct7_i == F7_ALT) begin
        if (funct3_i == 3'b000)      op_raw = OP_SUB;
        else if (funct3_i == 3'b101) op_raw = OP_SRA;
        else                         bad    = 1'b1;
`ifdef ALU_CONTROL_M_EXT_EN
      end else if (funct7_i == F7_MEXT) begin
        md_o = 1'b1;
        case (funct3_i)
          3'b000:  op_raw = OP_MUL;
          3'b001:  op_raw = OP_MULH;
          3'b100:  op_raw = OP_DIV;
          3'b110:  op_raw = OP_REM;
          default: begin
            bad  = 1'b1;
            md_o = 1'b0;
          end
        endcase
`endif
      end else begin
        bad = 1'b1;
      end
    end else if (alu_op_i == ALU_OP_W'(CLS_I)) begin
      // Immediate shifts are the only I-type encodings where funct7 matters
      if (funct3_i == 3'b001) begin
        if (funct7_i == F7_BASE) op_raw = OP_SLL;
        else                     bad    = 1'b1;
      end else if (funct3_i == 3'b101) begin
        if (funct7_i == F7_BASE)     op_raw = OP_SRL;
        else if (funct7_i == F7_ALT) op_raw = OP_SRA;
        else                         bad    = 1'b1;
      end else begin
        op_raw = f3_to_op(funct3_i);
      end
    end else if (alu_op_i == ALU_OP_W'(CLS_MEM)) begin
      op_raw = OP_ADD;
    end else if (alu_op_i == ALU_OP_W'(CLS_BR)) begin
      op_raw = OP_SUB;
    end else if (alu_op_i == ALU_OP_W'(CLS_LUI)) begin
      op_raw = OP_LUI;
    end else begin
      bad = 1'b1;
    end
  end

  assign op_o      = bad ? OP_ADD : op_raw;
  assign illegal_o = bad;

endmodule

// File: rtl/alu_control_mc.sv
// ALU control with IDLE/BUSY FSM: single-cycle ops answer next cycle, M ops after MD_LATENCY cycles.
// ALU_CONTROL_M_EXT_EN enables multiply/divide; without it BUSY is unreachable and busy_o is 0.
module alu_control_mc
  import alu_control_mc_pkg::*;
#(
  parameter int ALU_OP_W   = 3,
  parameter int ALU_SEL_W  = 4,
  parameter int MD_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_i,
  input  logic [ALU_OP_W-1:0]  ALU_Op_i,
  input  logic [2:0]           funct3_i,
  input  logic [6:0]           funct7_i,
  input  logic                 flush_i,
  output logic                 ready_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic                 illegal_o,
  output logic [ALU_SEL_W-1:0] ALU_Operation_o
);

  localparam int CNT_W = $clog2(MD_LATENCY);

  alu_sel_t dec_op;
  logic     dec_illegal;
  logic     dec_md;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 valid_q;
  logic                 illegal_q;
  logic [ALU_SEL_W-1:0] op_q;

  alu_decode_table #(.ALU_OP_W(ALU_OP_W)) u_decode (
    .alu_op_i  (ALU_Op_i),
    .funct3_i  (funct3_i),
    .funct7_i  (funct7_i),
    .op_o      (dec_op),
    .illegal_o (dec_illegal),
    .md_o      (dec_md)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      op_q      <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid_i && !flush_i) begin
            op_q      <= ALU_SEL_W'(dec_op);
            illegal_q <= dec_illegal;
            if (dec_md) begin
              cnt_q   <= CNT_W'(MD_LATENCY - 1);
              state_q <= ST_BUSY;
            end else begin
              valid_q <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          // valid_q is raised one cycle early so it lines up with cnt_q reaching zero
          if (flush_i) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else if (cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) valid_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign ready_o         = (state_q == ST_IDLE);
  assign valid_o         = valid_q;
  assign illegal_o       = illegal_q;
  assign ALU_Operation_o = op_q;

`ifdef ALU_CONTROL_M_EXT_EN
  assign busy_o = (state_q == ST_BUSY);
`else
  assign busy_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control_mc.sv
// Scoreboard bench for alu_control_mc: driver queues expected {op, illegal, cycle}, monitor checks valid_o.
module tb_alu_control_mc;

  localparam int MD_LAT = 4;

  logic       clk;
  logic       reset;
  logic       valid_i;
  logic [2:0] ALU_Op_i;
  logic [2:0] funct3_i;
  logic [6:0] funct7_i;
  logic       flush_i;
  logic       ready_o;
  logic       valid_o;
  logic       busy_o;
  logic       illegal_o;
  logic [3:0] ALU_Operation_o;

  alu_control_mc #(.ALU_OP_W(3), .ALU_SEL_W(4), .MD_LATENCY(MD_LAT)) dut (
    .clk             (clk),
    .reset           (reset),
    .valid_i         (valid_i),
    .ALU_Op_i        (ALU_Op_i),
    .funct3_i        (funct3_i),
    .funct7_i        (funct7_i),
    .flush_i         (flush_i),
    .ready_o         (ready_o),
    .valid_o         (valid_o),
    .busy_o          (busy_o),
    .illegal_o       (illegal_o),
    .ALU_Operation_o (ALU_Operation_o)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic        ill;
    logic [31:0] cyc;
  } exp_t;

  typedef struct packed {
    logic [2:0] cls;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] op;
    logic       ill;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  vec_t vecs [21] = '{
    '{3'b000, 3'b000, 7'h00, 4'b0000, 1'b0},
    '{3'b000, 3'b111, 7'h00, 4'b0010, 1'b0},
    '{3'b000, 3'b110, 7'h00, 4'b0011, 1'b0},
    '{3'b000, 3'b100, 7'h00, 4'b0100, 1'b0},
    '{3'b000, 3'b101, 7'h00, 4'b0110, 1'b0},
    '{3'b000, 3'b001, 7'h00, 4'b0111, 1'b0},
    '{3'b000, 3'b101, 7'h20, 4'b1000, 1'b0},
    '{3'b000, 3'b010, 7'h00, 4'b1001, 1'b0},
    '{3'b000, 3'b011, 7'h00, 4'b1010, 1'b0},
    '{3'b000, 3'b010, 7'h20, 4'b0000, 1'b1},
    '{3'b000, 3'b000, 7'h02, 4'b0000, 1'b1},
    '{3'b001, 3'b000, 7'h55, 4'b0000, 1'b0},
    '{3'b001, 3'b111, 7'h7F, 4'b0010, 1'b0},
    '{3'b001, 3'b001, 7'h20, 4'b0000, 1'b1},
    '{3'b001, 3'b101, 7'h00, 4'b0110, 1'b0},
    '{3'b001, 3'b101, 7'h20, 4'b1000, 1'b0},
    '{3'b010, 3'b011, 7'h12, 4'b0000, 1'b0},
    '{3'b011, 3'b001, 7'h00, 4'b0001, 1'b0},
    '{3'b101, 3'b000, 7'h00, 4'b0000, 1'b1},
    '{3'b111, 3'b000, 7'h00, 4'b0000, 1'b1},
    '{3'b001, 3'b011, 7'h00, 4'b1010, 1'b0}
  };

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one request; lat>0 queues an expected response lat cycles after the issue cycle
  task automatic send(input logic [2:0] cls, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [3:0] eop, input logic eill, input int lat);
    ALU_Op_i = cls;
    funct3_i = f3;
    funct7_i = f7;
    valid_i  = 1'b1;
    if (lat > 0) sb.push_back('{eop, eill, 32'(cyc + lat)});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i = 1'b0;
  endtask

  // Monitor: every valid_o pulse must match the oldest queued expectation, including its cycle
  always @(negedge clk) begin
    if (!reset && valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(valid_o), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("op", 32'(ALU_Operation_o), 32'(e.op));
        chk("illegal", 32'(illegal_o), 32'(e.ill));
        chk("valid_cycle", 32'(cyc), e.cyc);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(ready_o), 32'd1);
    chk({tag, "_valid"}, 32'(valid_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal_o), 32'd0);
    chk({tag, "_op"}, 32'(ALU_Operation_o), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    valid_i  = 1'b0;
    flush_i  = 1'b0;
    ALU_Op_i = '0;
    funct3_i = '0;
    funct7_i = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    send(3'b000, 3'b000, 7'h20, 4'b0001, 1'b0, 1);
    idle();
    @(posedge clk); #1;

    // ADDI, ORI, LUI back to back
    send(3'b001, 3'b000, 7'h00, 4'b0000, 1'b0, 1);
    send(3'b001, 3'b110, 7'h00, 4'b0011, 1'b0, 1);
    send(3'b100, 3'b000, 7'h00, 4'b0101, 1'b0, 1);
    idle();
    @(posedge clk); #1;

    foreach (vecs[i]) send(vecs[i].cls, vecs[i].f3, vecs[i].f7, vecs[i].op, vecs[i].ill, 1);
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Flush in IDLE blocks a simultaneous request
    flush_i = 1'b1;
    send(3'b000, 3'b100, 7'h00, 4'b0100, 1'b0, 0);
    flush_i = 1'b0;
    idle();
    @(negedge clk);
    chk("flush_idle_valid", 32'(valid_o), 32'd0);

    // Asynchronous reset clears nonzero registered outputs immediately
    send(3'b000, 3'b100, 7'h00, 4'b0100, 1'b0, 1);
    idle();
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;

`ifdef ALU_CONTROL_M_EXT_EN
    // DIV: busy for MD_LAT cycles, requests during BUSY ignored
    send(3'b000, 3'b100, 7'h01, 4'b1101, 1'b0, MD_LAT);
    for (int k = 0; k < MD_LAT; k++) begin
      @(negedge clk);
      chk("div_ready", 32'(ready_o), 32'd0);
      chk("div_busy", 32'(busy_o), 32'd1);
      if (k == 0) begin
        ALU_Op_i = 3'b000; funct3_i = 3'b000; funct7_i = 7'h00;
      end
      if (k == 2) idle();
    end
    @(negedge clk);
    chk("div_done_ready", 32'(ready_o), 32'd1);
    chk("div_done_busy", 32'(busy_o), 32'd0);

    send(3'b000, 3'b001, 7'h01, 4'b1100, 1'b0, MD_LAT);
    idle();
    repeat (MD_LAT + 1) @(negedge clk);
    send(3'b000, 3'b010, 7'h01, 4'b0000, 1'b1, 1);
    idle();
    @(posedge clk); #1;

    // MUL flushed in its second BUSY cycle
    send(3'b000, 3'b000, 7'h01, 4'b1011, 1'b0, 0);
    idle();
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_ready", 32'(ready_o), 32'd1);
    chk("flush_busy", 32'(busy_o), 32'd0);
    send(3'b000, 3'b000, 7'h00, 4'b0000, 1'b0, 1);
    idle();
    repeat (MD_LAT) @(negedge clk);

    // Reset while BUSY discards the operation
    send(3'b000, 3'b110, 7'h01, 4'b1110, 1'b0, 0);
    idle();
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk_zero("reset_busy");
    @(negedge clk);
    reset = 1'b0;
    repeat (MD_LAT) @(negedge clk);
`else
    // Without the M extension, MUL is an illegal single-cycle op
    send(3'b000, 3'b000, 7'h01, 4'b0000, 1'b1, 1);
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("nomext_busy", 32'(busy_o), 32'd0);
      chk("nomext_ready", 32'(ready_o), 32'd1);
    end
`endif

    // SRAI without a valid shift funct7
    send(3'b001, 3'b101, 7'h01, 4'b0000, 1'b1, 1);
    idle();

    for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
    @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
